arb_input_buffer: RTL and testbench

ARB_INPUT_BUFFER -- requirements
Module: arb_input_buffer

---
 rtl/arb_input_buffer.sv | 147 ++++++++++++++
 tb/tb_arb_input_buffer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_input_buffer.sv
// arb_input_buffer
// Per-input flit FIFOs in front of an external round-robin arbiter.
// Each input owns a DEPTH-entry FIFO; non-empty FIFOs raise req while the
// single output slot can take a flit. A qualified grant pops the FIFO head
// into the registered output slot one cycle later.
//
// Optional feature: define ARB_IBUF_CHECK_EN to build a sticky grant
// protocol checker driving err. Without it err is tied low and no checker
// logic exists.
module arb_input_buffer #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic [N-1:0]   req,
    input  logic [N-1:0]   grant,
    input  logic           anyGrant,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [N-1:0]   out_src,
    input  logic           out_ready,
    output logic           err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic           slot_free;
    logic [N-1:0]   push;
    logic [N-1:0]   pop;
    logic [W-1:0]   head_data [N];
    logic [W-1:0]   pop_data;

    logic           out_valid_reg;
    logic [W-1:0]   out_data_reg;
    logic [N-1:0]   out_src_reg;

    // The output slot can take a new flit when empty or being drained now.
    assign slot_free = ~out_valid_reg | out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fifo
            logic [W-1:0]  mem_reg [DEPTH];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [AW:0]   count_reg;
            logic [AW:0]   count_next;

            // Ready comes from the count register only: a full FIFO never
            // accepts, even when it is being popped in the same cycle.
            assign in_ready[gi]  = (count_reg != DEPTH_C);
            assign req[gi]       = (count_reg != '0) & slot_free;
            assign push[gi]      = in_valid[gi] & in_ready[gi];
            // Grant bits without a matching request are ignored.
            assign pop[gi]       = anyGrant & grant[gi] & req[gi];
            assign head_data[gi] = mem_reg[rd_ptr_reg];

            // Flit storage write; contents are not reset.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_reg[wr_ptr_reg] <= in_data[gi*W +: W];
                end
            end

            // Occupancy update; push and pop together leave it unchanged.
            always_comb begin
                count_next = count_reg;
                case ({push[gi], pop[gi]})
                    2'b10:   count_next = count_reg + 1'b1;
                    2'b01:   count_next = count_reg - 1'b1;
                    default: count_next = count_reg;
                endcase
            end

            // Pointer and count registers; pointers wrap modulo DEPTH.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_next;
                end
            end
        end
    endgenerate

    // Select the popped head; with a legal one-hot grant exactly one term is set.
    always_comb begin
        pop_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) pop_data = pop_data | head_data[i];
        end
    end

    // Output slot: load on pop, clear once consumed, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else if (|pop) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= pop_data;
            out_src_reg   <= pop;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

`ifdef ARB_IBUF_CHECK_EN
    logic err_reg;
    logic grant_bad;

    // A live grant must be one-hot and land on a requesting input.
    assign grant_bad = anyGrant &
                       (((grant & (grant - 1'b1)) != '0) |
                        (grant == '0) |
                        ((grant & ~req) != '0));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else if (grant_bad) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_input_buffer.sv
// Scoreboard bench for arb_input_buffer: directed stimulus pushes expected
// output flits into a queue; a monitor pops and compares on each consumed flit.
module tb_arb_input_buffer;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

`ifdef ARB_IBUF_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           anyGrant;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [N-1:0]   out_src;
    logic           out_ready;
    logic           err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [N-1:0] s;
    } exp_t;
    exp_t sbq[$];

    arb_input_buffer #(.N(N), .W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .req(req), .grant(grant), .anyGrant(anyGrant),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic expect_flit(input logic [W-1:0] d, input logic [N-1:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        sbq.push_back(e);
    endtask

    task automatic set_grant(input logic [N-1:0] g, input logic a);
        grant    = g;
        anyGrant = a;
    endtask

    // Monitor: a flit is consumed at the next rising edge when valid & ready.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL out_flit: got data %h src %h, expected no flit", out_data, out_src);
            end else begin
                e = sbq.pop_front();
                if (out_data !== e.d || out_src !== e.s) begin
                    errors++;
                    $display("FAIL out_flit: got data %h src %h, expected data %h src %h",
                             out_data, out_src, e.d, e.s);
                end else begin
                    $display("ok   out_flit data %h src %h", out_data, out_src);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        grant     = '0;
        anyGrant  = 1'b0;
        out_ready = 1'b0;
        repeat (3) cyc();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 8'hFF);
        chk("rst_req", req, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        reset = 1'b1;
        cyc();

        // Single flit through input 3
        out_ready = 1'b1;
        in_valid = 8'h08;
        in_data[3*W +: W] = 16'hA5A5;
        chk("req_before_push", req, 8'h00);
        cyc();
        in_valid = '0;
        chk("req_after_push", req, 8'h08);
        set_grant(8'h08, 1'b1);
        expect_flit(16'hA5A5, 8'h08);
        cyc();
        set_grant('0, 1'b0);
        chk("out_valid_after_grant", out_valid, 1);
        chk("out_src_after_grant", out_src, 8'h08);
        cyc();
        chk("out_valid_drained", out_valid, 0);

        // Fill input 0, overflow attempt, drain in order
        for (int k = 0; k < 4; k++) begin
            in_valid = 8'h01;
            in_data[0 +: W] = 16'h1000 + 16'(k);
            cyc();
        end
        chk("in_ready_full", in_ready, 8'hFE);
        in_data[0 +: W] = 16'hDEAD;
        cyc();
        in_valid = '0;
        chk("in_ready_full_after_5th", in_ready, 8'hFE);
        for (int k = 0; k < 4; k++) begin
            chk("req0_nonempty", req[0], 1);
            set_grant(8'h01, 1'b1);
            expect_flit(16'h1000 + 16'(k), 8'h01);
            cyc();
        end
        set_grant('0, 1'b0);
        chk("req_after_drain", req, 8'h00);
        chk("in_ready_after_drain", in_ready, 8'hFF);
        cyc();
        cyc();

        // Backpressure on the output slot
        in_valid = 8'h04;
        in_data[2*W +: W] = 16'h2222;
        cyc();
        in_data[2*W +: W] = 16'h2223;
        cyc();
        in_valid = '0;
        out_ready = 1'b0;
        chk("req_slot_empty", req, 8'h04);
        set_grant(8'h04, 1'b1);
        expect_flit(16'h2222, 8'h04);
        cyc();
        set_grant('0, 1'b0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_req_masked", req, 8'h00);
        cyc();
        cyc();
        chk("bp_out_data_held", out_data, 16'h2222);
        chk("bp_out_valid_held", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_req_reasserted", req, 8'h04);
        set_grant(8'h04, 1'b1);
        expect_flit(16'h2223, 8'h04);
        cyc();
        set_grant('0, 1'b0);
        cyc();
        cyc();

        // Grant without anyGrant pops nothing
        in_valid = 8'h42;
        in_data[1*W +: W] = 16'h0111;
        in_data[6*W +: W] = 16'h0666;
        cyc();
        in_valid = '0;
        set_grant(8'h40, 1'b0);
        cyc();
        set_grant('0, 1'b0);
        chk("nogrant_req", req, 8'h42);
        chk("nogrant_out_valid", out_valid, 0);
        set_grant(8'h02, 1'b1);
        expect_flit(16'h0111, 8'h02);
        cyc();
        set_grant(8'h40, 1'b1);
        expect_flit(16'h0666, 8'h40);
        cyc();
        set_grant('0, 1'b0);
        chk("req_after_1_6", req, 8'h00);
        cyc();

        // Pushes on every input plus a pop on input 5 in one cycle
        in_valid = 8'h20;
        in_data[5*W +: W] = 16'h0555;
        cyc();
        in_valid = 8'hFF;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'hB000 + 16'(i);
        set_grant(8'h20, 1'b1);
        expect_flit(16'h0555, 8'h20);
        cyc();
        in_valid = '0;
        set_grant('0, 1'b0);
        chk("allpush_in_ready", in_ready, 8'hFF);
        chk("allpush_req", req, 8'hFF);
        for (int i = 0; i < N; i++) begin
            set_grant(8'(1 << i), 1'b1);
            expect_flit(16'hB000 + 16'(i), 8'(1 << i));
            cyc();
        end
        set_grant('0, 1'b0);
        chk("allpush_req_drained", req, 8'h00);
        cyc();
        cyc();

        // Non-one-hot grant: only the requesting input pops
        in_valid = 8'h01;
        in_data[0 +: W] = 16'h0C0C;
        cyc();
        in_valid = '0;
        chk("err_before", err, 0);
        set_grant(8'h03, 1'b1);
        expect_flit(16'h0C0C, 8'h01);
        cyc();
        set_grant('0, 1'b0);
        chk("err_after_bad_grant", err, EXP_ERR);
        chk("req_after_bad_grant", req, 8'h00);
        cyc();
        cyc();
        chk("err_sticky", err, EXP_ERR);

        // Reset mid-operation with buffered flits and a held output
        out_ready = 1'b0;
        in_valid = 8'h90;
        in_data[4*W +: W] = 16'h4440;
        in_data[7*W +: W] = 16'h0777;
        cyc();
        in_valid = 8'h10;
        in_data[4*W +: W] = 16'h4441;
        cyc();
        in_data[4*W +: W] = 16'h4442;
        cyc();
        in_valid = '0;
        set_grant(8'h80, 1'b1);
        cyc();
        set_grant('0, 1'b0);
        chk("prerst_out_valid", out_valid, 1);
        chk("prerst_req", req, 8'h00);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_req", req, 8'h00);
        chk("midrst_in_ready", in_ready, 8'hFF);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_src", out_src, 0);
        chk("midrst_err", err, 0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("postrst_req", req, 8'h00);
        chk("postrst_in_ready", in_ready, 8'hFF);
        out_ready = 1'b1;
        in_valid = 8'h10;
        in_data[4*W +: W] = 16'h4999;
        cyc();
        in_valid = '0;
        chk("postrst_req_new", req, 8'h10);
        set_grant(8'h10, 1'b1);
        expect_flit(16'h4999, 8'h10);
        cyc();
        set_grant('0, 1'b0);
        cyc();
        cyc();
        chk("postrst_req_empty", req, 8'h00);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
